uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path (tx FIFO write side: wr_uart / w_data / tx_full) between NREQ byte-stream requesters.
- Grants whole packets (byte sequence terminated by a last flag) so bytes from different requesters never interleave on the serial line.
- Uses round-robin fairness.
- Sits between the requesters and the uart top-level's wr_uart/w_data/tx_full ports.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit-path arbiter.
// Optional feature macro used by the arbiter: UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DBIT = 8;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin selector: first set request strictly after the last-served
// index, wrapping around, so the last-served requester is tried last.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant,
  output logic            any
);

  logic [ID_W-1:0] idx;

  // Scan from last+1 upward with wrap; keep the first hit.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ID_W'((int'(last) + i) % NREQ);
      if (!any && req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the UART tx FIFO write port.
// A grant lasts until the granted requester transfers a byte flagged last.
// Optional mid-packet stall timeout: define UART_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin, no transfer
// BUSY  | grant_id owns the FIFO write port until its last byte
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int NREQ    = DEF_NREQ,
  parameter int TIMEOUT = 255,
  localparam int ID_W   = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  // Reject configurations the index and counter widths cannot represent.
  if (NREQ < 2 || NREQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be 2..16 and TIMEOUT >= 1");
  end

  arb_state_t      state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] pick_id;
  logic            pick_any;
  logic [DBIT-1:0] slice [NREQ];
  logic            cur_valid;
  logic            cur_last;
  logic            xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign slice[i] = req_data[i*DBIT +: DBIT];
  end

  assign busy      = (state == BUSY);
  assign cur_valid = req_valid[grant_id];
  assign cur_last  = req_last[grant_id];
  assign xfer      = busy & cur_valid & ~tx_full;

  uart_rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .req   (req_valid),
    .last  (last_id),
    .grant (pick_id),
    .any   (pick_any)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] stall_cnt;
  logic            to_pulse;
  assign timeout_err = to_pulse;
`else
  assign timeout_err = 1'b0;
`endif

  // Grant FSM: arbitrate in IDLE, hold the grant through the whole packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= ID_W'(NREQ - 1);
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt <= '0;
      to_pulse  <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_TIMEOUT_EN
      to_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_id <= pick_id;
            state    <= BUSY;
`ifdef UART_ARB_TIMEOUT_EN
            stall_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (xfer && cur_last) begin
            last_id <= grant_id;
            state   <= IDLE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Only valid-low cycles count; tx_full back-pressure never revokes.
          if (xfer) begin
            stall_cnt <= '0;
          end else if (!cur_valid) begin
            if (stall_cnt == TO_W'(TIMEOUT - 1)) begin
              state     <= IDLE;
              last_id   <= grant_id;
              to_pulse  <= 1'b1;
              stall_cnt <= '0;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the granted requester to the FIFO port; everything quiet when idle.
  always_comb begin
    req_ready = '0;
    wr_uart   = 1'b0;
    w_data    = '0;
    if (busy) begin
      req_ready[grant_id] = ~tx_full;
      wr_uart             = cur_valid & ~tx_full;
      w_data              = slice[grant_id];
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by a
// randomized phase, all compared against a packet-level reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ    = 4;
  localparam int DBIT    = 8;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DBIT(DBIT), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_full     (tx_full),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Requester-side packet queues (byte + last flag).
  logic [DBIT-1:0] qd [NREQ][$];
  bit              ql [NREQ][$];
  bit              hold_low [NREQ];
  bit              force_full;
  int              p_full, p_stall;

  // Reference model: current owner (-1 = none), last served, stall count.
  int m_owner, m_last, m_gid, m_idle;
  bit m_to;

  int cyc, tests, fails;
  int              log_id [$];
  int              log_cyc [$];
  logic [DBIT-1:0] log_dat [$];

  logic            s_busy, s_wr, s_to;
  logic [NREQ-1:0] s_ready;
  logic [ID_W-1:0] s_gid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_pkt(input int r, input int n, input logic [DBIT-1:0] first, input bit rnd);
    for (int k = 0; k < n; k++) begin
      qd[r].push_back(rnd ? DBIT'($urandom) : first + DBIT'(k));
      ql[r].push_back(k == n - 1);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NREQ; i++) s += qd[i].size();
    return s;
  endfunction

  function automatic logic [31:0] get_dat(input int k);
    return (k < log_dat.size()) ? 32'(log_dat[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] get_id(input int k);
    return (k < log_id.size()) ? 32'(log_id[k]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] get_cyc(input int k);
    return (k < log_cyc.size()) ? 32'(log_cyc[k]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_log();
    log_id.delete();
    log_cyc.delete();
    log_dat.delete();
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_gid   = 0;
    m_idle  = 0;
    m_to    = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bit has;
      has = (qd[i].size() != 0);
      req_data[i*DBIT +: DBIT] = has ? qd[i][0] : '0;
      req_last[i]  = has ? ql[i][0] : 1'b0;
      req_valid[i] = has && !hold_low[i] && !(int'($urandom_range(99)) < p_stall);
    end
    tx_full = force_full || (int'($urandom_range(99)) < p_full);
  endtask

  // One clock: drive at negedge, check combinational/registered outputs,
  // then advance requester queues and the model at the posedge.
  task automatic cycle(input bit rst);
    logic [NREQ-1:0] e_ready;
    logic [DBIT-1:0] e_dat;
    bit e_wr, e_busy, e_lastb;
    int o;
    @(negedge clk);
    reset = rst;
    drive();
    #1;
    o = m_owner;
    e_ready = '0; e_wr = 0; e_dat = '0; e_busy = 0; e_lastb = 0;
    if (o >= 0) begin
      e_busy     = 1;
      e_ready[o] = !tx_full;
      e_wr       = req_valid[o] && !tx_full;
      e_dat      = req_data[o*DBIT +: DBIT];
      e_lastb    = req_last[o];
    end
    s_busy = busy; s_wr = wr_uart; s_to = timeout_err; s_ready = req_ready; s_gid = grant_id;
    chk("busy", busy, e_busy);
    chk("grant_id", grant_id, m_gid);
    chk("wr_uart", wr_uart, e_wr);
    chk("req_ready", req_ready, e_ready);
    chk("w_data", w_data, e_dat);
    chk("timeout_err", timeout_err, m_to);
    if (wr_uart === 1'b1) begin
      log_id.push_back(int'(grant_id));
      log_cyc.push_back(cyc);
      log_dat.push_back(w_data);
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && s_ready[i] && qd[i].size() != 0) begin
        void'(qd[i].pop_front());
        void'(ql[i].pop_front());
      end
    end
    m_to = 0;
    if (rst) begin
      model_reset();
    end else if (o < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (m_owner < 0 && req_valid[c]) begin
          m_owner = c;
          m_gid   = c;
          m_idle  = 0;
        end
      end
    end else if (e_wr && e_lastb) begin
      m_last  = o;
      m_owner = -1;
    end
`ifdef UART_ARB_TIMEOUT_EN
    else if (e_wr) begin
      m_idle = 0;
    end else if (!req_valid[o]) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_last  = o;
        m_owner = -1;
        m_idle  = 0;
        m_to    = 1;
      end
    end
`endif
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      cycle(0);
      n++;
    end
    chk(tag, pending(), 0);
    repeat (2) cycle(0);
  endtask

  initial begin
    int t0, r;
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    force_full = 0; p_full = 0; p_stall = 0;
    cyc = 0; tests = 0; fails = 0;
    model_reset();
    repeat (3) @(posedge clk);
    cycle(1);

    // Reset state and idle behaviour.
    cycle(0);
    chk("rst_busy", s_busy, 0);
    chk("rst_gid", s_gid, 0);
    chk("rst_wr", s_wr, 0);
    chk("rst_ready", s_ready, 0);

    // Single 3-byte packet from requester 0.
    clear_log();
    push_pkt(0, 3, 8'hA1, 0);
    t0 = cyc;
    repeat (6) cycle(0);
    chk("t1_count", log_dat.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_data", get_dat(k), 32'hA1 + k);
      chk("t1_cyc", get_cyc(k), t0 + 1 + k);
      chk("t1_id", get_id(k), 0);
    end
    chk("t1_busy_end", s_busy, 0);

    // All four requesters at once: order 0,1,2,3 with one bubble between.
    cycle(1);
    clear_log();
    for (int i = 0; i < NREQ; i++) push_pkt(i, 2, DBIT'(16 * (i + 1)), 0);
    drain("t2_drain", 40);
    chk("t2_count", log_dat.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_id", get_id(k), k / 2);
      chk("t2_data", get_dat(k), 16 * (k / 2 + 1) + (k % 2));
      if (k < 7) chk("t2_gap", get_cyc(k + 1) - get_cyc(k), (k % 2 == 0) ? 1 : 2);
    end

    // Requester 2 stalled by tx_full for 5 cycles mid-packet.
    cycle(1);
    clear_log();
    push_pkt(2, 3, 8'hC0, 0);
    cycle(0);
    cycle(0);
    chk("t3_first_wr", s_wr, 1);
    force_full = 1;
    repeat (5) begin
      cycle(0);
      chk("t3_full_wr", s_wr, 0);
      chk("t3_full_rdy", s_ready[2], 0);
      chk("t3_full_busy", s_busy, 1);
    end
    force_full = 0;
    cycle(0);
    chk("t3_resume_wr", s_wr, 1);
    repeat (3) cycle(0);
    chk("t3_count", log_dat.size(), 3);
    for (int k = 0; k < 3; k++) chk("t3_data", get_dat(k), 32'hC0 + k);

`ifndef UART_ARB_TIMEOUT_EN
    // Requester 1 goes quiet mid-packet; requester 3 must wait.
    cycle(1);
    clear_log();
    push_pkt(1, 3, 8'h50, 0);
    push_pkt(3, 2, 8'h70, 0);
    cycle(0);
    cycle(0);
    hold_low[1] = 1;
    repeat (10) begin
      cycle(0);
      chk("t4_hold_gid", s_gid, 1);
      chk("t4_hold_wr", s_wr, 0);
      chk("t4_hold_busy", s_busy, 1);
    end
    hold_low[1] = 0;
    drain("t4_drain", 30);
    chk("t4_count", log_dat.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t4_id", get_id(k), (k < 3) ? 1 : 3);
      chk("t4_data", get_dat(k), (k < 3) ? 32'h50 + k : 32'h70 + k - 3);
    end
`else
    // Requester 0 goes quiet mid-packet; grant revoked after TIMEOUT cycles.
    cycle(1);
    clear_log();
    push_pkt(0, 3, 8'h80, 0);
    push_pkt(1, 2, 8'h90, 0);
    cycle(0);
    cycle(0);
    hold_low[0] = 1;
    repeat (TIMEOUT) begin
      cycle(0);
      chk("t5_stall_to", s_to, 0);
      chk("t5_stall_busy", s_busy, 1);
    end
    cycle(0);
    chk("t5_to_pulse", s_to, 1);
    chk("t5_to_busy", s_busy, 0);
    cycle(0);
    chk("t5_to_clear", s_to, 0);
    chk("t5_next_busy", s_busy, 1);
    chk("t5_next_gid", s_gid, 1);
    hold_low[0] = 0;
    drain("t5_drain", 30);
`endif

    // Reset while busy mid-packet; next arbitration starts at requester 0.
    cycle(1);
    push_pkt(2, 6, 8'hE0, 0);
    repeat (3) cycle(0);
    push_pkt(0, 1, 8'h33, 0);
    cycle(1);
    cycle(0);
    chk("t6_busy", s_busy, 0);
    chk("t6_wr", s_wr, 0);
    chk("t6_ready", s_ready, 0);
    cycle(0);
    chk("t6_busy_next", s_busy, 1);
    chk("t6_gid_next", s_gid, 0);
    drain("t6_drain", 40);

    // Randomized traffic with back-pressure and valid gaps.
    cycle(1);
    p_full = 25;
    p_stall = 15;
    repeat (1500) begin
      if ($urandom_range(9) == 0) begin
        r = int'($urandom_range(NREQ - 1));
        if (qd[r].size() < 12) push_pkt(r, int'($urandom_range(5, 1)), '0, 1);
      end
      cycle(0);
    end
    p_full = 0;
    p_stall = 0;
    drain("rand_drain", 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
